// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the SPI command decoder and the configuration
//   register file: frame opcodes, register addresses and the writer's
//   state encoding.
package regfile_pkg;

  // Frame opcodes (first byte of every chip-select frame).
  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_DATA_WR = 8'h2C;

  // Register file map.
  localparam logic [2:0] REG_T0H      = 3'd0;
  localparam logic [2:0] REG_T0S      = 3'd1;
  localparam logic [2:0] REG_T1H      = 3'd2;
  localparam logic [2:0] REG_T1S      = 3'd3;
  localparam logic [2:0] REG_CHAN_LEN = 3'd4;
  localparam logic [2:0] REG_CHAN_CNT = 3'd5;
  localparam logic [2:0] REG_LAST     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_CONF,
    ST_DATA,
    ST_DROP
  } writer_state_e;

  // State entered after an opcode byte; unknown opcodes discard the frame.
  function automatic writer_state_e decode_opcode(input logic [7:0] op);
    case (op)
      CMD_CONF_WR: return ST_ADDR;
      CMD_DATA_WR: return ST_DATA;
      default:     return ST_DROP;
    endcase
  endfunction

endpackage

// File: rtl/regfile_writer.sv
// regfile_writer
//   Parses chip-select-delimited SPI frames and turns them into single-cycle
//   writes on the register-file port (CONF_WR frames) or the pixel RAM port
//   (DATA_WR frames). Pulses frame_done_o when a pixel frame that carried at
//   least one byte closes.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   spi_cs_n_i              frame select (synchronised), low = frame active
//   spi_byte_vld_i          one-cycle strobe, spi_byte_data_i valid
//   spi_byte_data_i [7:0]   received byte
//   reg_wr_en_o/addr/data   register write port (addr 3 bits, data 8 bits)
//   ram_wr_en_o/addr/data   pixel RAM write port (addr RAM_AW bits, data 8)
//   frame_done_o            one-cycle pulse, pixel frame complete
module regfile_writer
  import regfile_pkg::*;
#(
  parameter int RAM_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_byte_vld_i,
  input  logic [7:0]        spi_byte_data_i,
  output logic              reg_wr_en_o,
  output logic [2:0]        reg_wr_addr_o,
  output logic [7:0]        reg_wr_data_o,
  output logic              ram_wr_en_o,
  output logic [RAM_AW-1:0] ram_wr_addr_o,
  output logic [7:0]        ram_wr_data_o,
  output logic              frame_done_o
);

  localparam logic [RAM_AW-1:0] RAM_LAST = '1;

  writer_state_e     state;
  writer_state_e     op_next;
  logic [2:0]        reg_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic              data_seen;

  assign op_next = decode_opcode(spi_byte_data_i);

  // NOTE: every register here is sequential state, so it is assigned with <=
  // only; blocking assignments would let later statements see updated values
  // within the same edge and break the one-cycle write timing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_IDLE;
      reg_addr      <= '0;
      ram_addr      <= '0;
      data_seen     <= 1'b0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      reg_wr_data_o <= '0;
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      frame_done_o  <= 1'b0;
    end else begin
      // Strobes are single-cycle; address/data outputs hold between writes.
      reg_wr_en_o  <= 1'b0;
      ram_wr_en_o  <= 1'b0;
      frame_done_o <= 1'b0;

      if (state != ST_IDLE && spi_cs_n_i) begin
        // Frame closed: any byte strobe in this cycle is dropped. data_seen
        // is only ever set by pixel bytes, so it alone decides frame_done.
        state        <= ST_IDLE;
        frame_done_o <= data_seen;
        data_seen    <= 1'b0;
      end else begin
        case (state)
          // IDLE decodes an opcode that arrives in the first cs_n-low cycle
          // exactly as CMD would, so the two states share this branch.
          ST_IDLE, ST_CMD: begin
            if (!spi_cs_n_i) begin
              if (spi_byte_vld_i) begin
                state <= op_next;
                if (op_next == ST_DATA) begin
                  ram_addr  <= '0;
                  data_seen <= 1'b0;
                end
              end else begin
                state <= ST_CMD;
              end
            end
          end

          ST_ADDR: begin
            if (spi_byte_vld_i) begin
              reg_addr <= spi_byte_data_i[2:0];
              // Full byte compared so values like 0x08 are rejected too.
              state    <= (spi_byte_data_i > {5'd0, REG_LAST}) ? ST_DROP : ST_CONF;
            end
          end

          ST_CONF: begin
            if (spi_byte_vld_i) begin
              reg_wr_en_o   <= 1'b1;
              reg_wr_addr_o <= reg_addr;
              reg_wr_data_o <= spi_byte_data_i;
              if (reg_addr == REG_LAST) state <= ST_DROP;
              else                      reg_addr <= reg_addr + 3'd1;
            end
          end

          ST_DATA: begin
            if (spi_byte_vld_i) begin
              ram_wr_en_o   <= 1'b1;
              ram_wr_addr_o <= ram_addr;
              ram_wr_data_o <= spi_byte_data_i;
              data_seen     <= 1'b1;
              if (ram_addr == RAM_LAST) state <= ST_DROP;
              else                      ram_addr <= ram_addr + RAM_AW'(1);
            end
          end

          ST_DROP: ;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer
//   Directed bench for regfile_writer. Two instances share the same stimulus:
//   one at the default RAM_AW and a RAM_AW=2 copy used for the overflow case.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_regfile_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       vld;
  logic [7:0] din;

  logic        reg_en,  ram_en,  done;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_data, ram_data;
  logic [11:0] ram_addr;

  logic        s_reg_en, s_ram_en, s_done;
  logic [2:0]  s_reg_addr;
  logic [7:0]  s_reg_data, s_ram_data;
  logic [1:0]  s_ram_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_writer #(.RAM_AW(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .spi_cs_n_i(cs_n),
    .spi_byte_vld_i(vld), .spi_byte_data_i(din),
    .reg_wr_en_o(reg_en), .reg_wr_addr_o(reg_addr), .reg_wr_data_o(reg_data),
    .ram_wr_en_o(ram_en), .ram_wr_addr_o(ram_addr), .ram_wr_data_o(ram_data),
    .frame_done_o(done)
  );

  regfile_writer #(.RAM_AW(2)) dut_small (
    .clk_i(clk), .rst_n_i(rst_n), .spi_cs_n_i(cs_n),
    .spi_byte_vld_i(vld), .spi_byte_data_i(din),
    .reg_wr_en_o(s_reg_en), .reg_wr_addr_o(s_reg_addr), .reg_wr_data_o(s_reg_data),
    .ram_wr_en_o(s_ram_en), .ram_wr_addr_o(s_ram_addr), .ram_wr_data_o(s_ram_data),
    .frame_done_o(s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 ns after the edge.
  task automatic step(input logic c, input logic v, input logic [7:0] d);
    cs_n = c;
    vld  = v;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_none(input string tag, input logic exp_done = 1'b0);
    check({tag, ".reg_en"}, 32'(reg_en), 32'd0);
    check({tag, ".ram_en"}, 32'(ram_en), 32'd0);
    check({tag, ".done"},   32'(done),   32'(exp_done));
  endtask

  task automatic expect_reg(input string tag, input logic [2:0] a, input logic [7:0] d);
    check({tag, ".reg_en"},   32'(reg_en),   32'd1);
    check({tag, ".reg_addr"}, 32'(reg_addr), 32'(a));
    check({tag, ".reg_data"}, 32'(reg_data), 32'(d));
    check({tag, ".ram_en"},   32'(ram_en),   32'd0);
  endtask

  task automatic expect_ram(input string tag, input logic [11:0] a, input logic [7:0] d);
    check({tag, ".ram_en"},   32'(ram_en),   32'd1);
    check({tag, ".ram_addr"}, 32'(ram_addr), 32'(a));
    check({tag, ".ram_data"}, 32'(ram_data), 32'(d));
    check({tag, ".reg_en"},   32'(reg_en),   32'd0);
  endtask

  task automatic expect_small(input string tag, input logic en, input logic [1:0] a,
                              input logic [7:0] d, input logic exp_done);
    check({tag, ".s_ram_en"}, 32'(s_ram_en), 32'(en));
    check({tag, ".s_done"},   32'(s_done),   32'(exp_done));
    if (en) begin
      check({tag, ".s_ram_addr"}, 32'(s_ram_addr), 32'(a));
      check({tag, ".s_ram_data"}, 32'(s_ram_data), 32'(d));
    end
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, ".reg_en"},   32'(reg_en),   32'd0);
    check({tag, ".reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, ".reg_data"}, 32'(reg_data), 32'd0);
    check({tag, ".ram_en"},   32'(ram_en),   32'd0);
    check({tag, ".ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, ".ram_data"}, 32'(ram_data), 32'd0);
    check({tag, ".done"},     32'(done),     32'd0);
    check({tag, ".s_ram_en"}, 32'(s_ram_en), 32'd0);
    check({tag, ".s_done"},   32'(s_done),   32'd0);
  endtask

  initial begin
    logic [7:0] conf_bytes [6];
    conf_bytes = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h3F, 8'h07};

    rst_n = 1'b0;
    cs_n  = 1'b1;
    vld   = 1'b0;
    din   = 8'h00;
    #12;
    expect_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    expect_none("idle");

    // Full CONF frame, opcode in the very first cs_n-low cycle.
    step(1'b0, 1'b1, 8'h2A); expect_none("conf_op");
    step(1'b0, 1'b1, 8'h00); expect_none("conf_addr");
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, conf_bytes[i]);
      expect_reg($sformatf("conf_wr%0d", i), 3'(i), conf_bytes[i]);
    end
    step(1'b1, 1'b0, 8'h00); expect_none("conf_end");
    step(1'b1, 1'b0, 8'h00); expect_none("conf_after");

    // CONF from address 4; extra byte after address 5 ignored.
    step(1'b0, 1'b0, 8'h00); expect_none("c4_gap");
    step(1'b0, 1'b1, 8'h2A); expect_none("c4_op");
    step(1'b0, 1'b1, 8'h04); expect_none("c4_addr");
    step(1'b0, 1'b1, 8'h3F); expect_reg("c4_wr4", 3'd4, 8'h3F);
    step(1'b0, 1'b1, 8'h07); expect_reg("c4_wr5", 3'd5, 8'h07);
    step(1'b0, 1'b1, 8'hAA); expect_none("c4_excess");
    check("c4_hold_addr", 32'(reg_addr), 32'd5);
    check("c4_hold_data", 32'(reg_data), 32'h07);
    step(1'b1, 1'b0, 8'h00); expect_none("c4_end");

    // Pixel frame, back-to-back bytes.
    step(1'b0, 1'b1, 8'h2C); expect_none("pix_op");
    step(1'b0, 1'b1, 8'h11); expect_ram("pix_wr0", 12'd0, 8'h11);
    step(1'b0, 1'b1, 8'h22); expect_ram("pix_wr1", 12'd1, 8'h22);
    step(1'b0, 1'b1, 8'h33); expect_ram("pix_wr2", 12'd2, 8'h33);
    step(1'b0, 1'b0, 8'h00); expect_none("pix_gap");
    step(1'b1, 1'b1, 8'h44); expect_none("pix_done", 1'b1);
    check("pix_hold_addr", 32'(ram_addr), 32'd2);
    check("pix_hold_data", 32'(ram_data), 32'h33);
    step(1'b1, 1'b0, 8'h00); expect_none("pix_after");

    // Bad opcode.
    step(1'b0, 1'b1, 8'h55); expect_none("bad_op");
    step(1'b0, 1'b1, 8'h01); expect_none("bad_op_b1");
    step(1'b0, 1'b1, 8'h02); expect_none("bad_op_b2");
    step(1'b1, 1'b0, 8'h00); expect_none("bad_op_end");

    // Bad register address.
    step(1'b0, 1'b1, 8'h2A); expect_none("bad_addr_op");
    step(1'b0, 1'b1, 8'h06); expect_none("bad_addr");
    step(1'b0, 1'b1, 8'h01); expect_none("bad_addr_b");
    step(1'b1, 1'b0, 8'h00); expect_none("bad_addr_end");

    // Empty pixel frame: no frame_done.
    step(1'b0, 1'b1, 8'h2C); expect_none("empty_op");
    step(1'b1, 1'b0, 8'h00); expect_none("empty_end");
    step(1'b1, 1'b0, 8'h00); expect_none("empty_after");

    // RAM overflow on the RAM_AW=2 instance.
    step(1'b0, 1'b1, 8'h2C); expect_small("ovf_op", 1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'(i + 1));
      expect_small($sformatf("ovf_wr%0d", i), 1'b1, 2'(i), 8'(i + 1), 1'b0);
    end
    step(1'b0, 1'b1, 8'h05); expect_small("ovf_excess", 1'b0, 2'd0, 8'h00, 1'b0);
    check("ovf_hold_addr", 32'(s_ram_addr), 32'd3);
    step(1'b1, 1'b0, 8'h00); expect_small("ovf_done", 1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00); expect_small("ovf_after", 1'b0, 2'd0, 8'h00, 1'b0);

    // Reset in the middle of a pixel frame.
    step(1'b0, 1'b1, 8'h2C); expect_none("rst_op");
    step(1'b0, 1'b1, 8'hAA); expect_ram("rst_wr0", 12'd0, 8'hAA);
    step(1'b0, 1'b1, 8'hBB); expect_ram("rst_wr1", 12'd1, 8'hBB);
    vld   = 1'b0;
    rst_n = 1'b0;
    #1;
    expect_all_zero("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h2C); expect_none("post_rst_op");
    step(1'b0, 1'b1, 8'h99); expect_ram("post_rst_wr", 12'd0, 8'h99);
    step(1'b1, 1'b0, 8'h00); expect_none("post_rst_done", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Both write strobes must never appear together.
  always @(negedge clk) begin
    if (rst_n && reg_en && ram_en) begin
      checks++;
      failures++;
      $display("FAIL both_strobes: reg_en=%0d ram_en=%0d required not both 1", reg_en, ram_en);
    end
  end

  // Hard time limit so the run always terminates on its own.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_writer.md
# regfile_writer

Command decoder between the SPI slave byte interface and the configuration/pixel storage. Parses each chip-select-delimited frame, issues single-cycle writes on the register-file write port (`reg_wr_*`) and the pixel RAM write port (`ram_wr_*`), and pulses `frame_done_o` when a pixel frame closes so the LED transmitter can start. It is the initiator for the register file's write port.

## Interface
- `RAM_AW`, default 12: pixel RAM address width.

- `clk_i` in 1: system clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `spi_cs_n_i` in 1: frame select, already synchronised to `clk_i`; low = frame active.
- `spi_byte_vld_i` in 1: one-cycle strobe, received byte valid.
- `spi_byte_data_i` in 8: received byte.
- `reg_wr_en_o` out 1: register write strobe.
- `reg_wr_addr_o` out 3: register address (0 T0H, 1 T0S, 2 T1H, 3 T1S, 4 CHAN_LEN, 5 CHAN_CNT).
- `reg_wr_data_o` out 8: register write data.
- `ram_wr_en_o` out 1: pixel RAM write strobe.
- `ram_wr_addr_o` out RAM_AW: pixel RAM address.
- `ram_wr_data_o` out 8: pixel RAM write data.
- `frame_done_o` out 1: one-cycle pulse, pixel frame complete.

## Operation
- States: IDLE, CMD, ADDR, CONF, DATA, DROP.
- IDLE: while `spi_cs_n_i` is high, stay here. When it is low, go to CMD.
- CMD: the first valid byte is the opcode.
  - 0x2A CONF_WR: go to ADDR.
  - 0x2C DATA_WR: clear the RAM address counter, clear `data_seen`, go to DATA.
  - Any other opcode: go to DROP.
- ADDR: on the next valid byte, load bits [2:0] into the register address counter.
  - Byte value > 5: go to DROP (no writes).
  - Otherwise go to CONF.
- CONF: each valid byte issues one register write at the counter address, then the counter increments. After the write to address 5, go to DROP. Register addresses never wrap.
- DATA: each valid byte issues one RAM write at the counter address, sets `data_seen`, then the counter increments.
  - After the write to address 2^RAM_AW−1, go to DROP with `data_seen` kept.
  - Excess bytes are discarded. RAM addresses never wrap.
- DROP: ignore all bytes until `spi_cs_n_i` goes high.
- `spi_cs_n_i` high in any non-IDLE state returns the FSM to IDLE on the next edge.
  - A byte strobe in the same cycle as cs_n high is ignored.
  - If the frame was DATA_WR with `data_seen` set (including after RAM-full DROP), pulse `frame_done_o`.
  - CONF frames and empty DATA frames do not pulse `frame_done_o`.
- Reset mid-frame: FSM goes to IDLE and all outputs go to 0. A frame still in progress when reset releases (cs_n low) is parsed from its next byte, which is treated as the opcode.

## Timing
- Reset value of every output is 0. Counters reset to 0; the FSM resets to IDLE.
- All outputs are registered. A write strobe is asserted exactly the cycle after the accepted `spi_byte_vld_i`, for one cycle. Address and data are valid in that cycle and hold their values afterwards.
- `reg_wr_en_o` and `ram_wr_en_o` are never asserted in the same cycle.
- `frame_done_o` is asserted the cycle after `spi_cs_n_i` is first sampled high.
- Back-to-back byte strobes on consecutive cycles must be accepted, giving one write per cycle.
- IDLE→CMD takes one cycle. A byte strobe in the first cs_n-low cycle is still taken as the opcode: IDLE evaluates the opcode directly when `spi_byte_vld_i` and cs_n low are seen together.

## Structure
- Shared package `regfile_pkg`:
  - Opcode constants CMD_CONF_WR = 8'h2A and CMD_DATA_WR = 8'h2C.
  - Register address constants REG_T0H … REG_CHAN_CNT, with REG_LAST = 3'd5.
  - The writer state enum.
- Single module, no sub-modules. The FSM, the two address counters and the output registers fit inline.

## Test plan
- Frame: cs_n low, bytes 2A 00 01 12 23 34 3F 07, cs_n high.
  - Response: six reg writes (0,01) (1,12) (2,23) (3,34) (4,3F) (5,07), each one cycle after its byte.
  - No `frame_done_o`.
- CONF from address 4: bytes 2A 04 3F 07 AA.
  - Response: writes (4,3F) (5,07) only; AA is ignored.
- Pixel frame: bytes 2C 11 22 33 on consecutive cycles, then cs_n high.
  - Response: RAM writes (0,11) (1,22) (2,33) on consecutive cycles.
  - One `frame_done_o` pulse the cycle after cs_n is seen high.
- Bad opcode and bad address:
  - Frame 55 01 02: no writes.
  - Frame 2A 06 01: no writes.
  - Frame 2C then cs_n high: no writes and no `frame_done_o`.
- RAM overflow with RAM_AW=2: bytes 2C 01 02 03 04 05.
  - Response: writes to addresses 0–3 only, then `frame_done_o` on cs_n rise.
- Reset asserted mid DATA frame after two bytes:
  - All outputs are 0 immediately.
  - After release, a new frame 2C 99 writes (0,99).
